// File: rtl/direction_normalize_pkg.sv
// direction_normalize_pkg: shared ray direction types and default fixed-point format
package direction_normalize_pkg;
  localparam int DIR_WIDTH = 16;
  localparam int DIR_Q_BITS = 8;
  typedef struct packed {
    logic signed [DIR_WIDTH-1:0] x;
    logic signed [DIR_WIDTH-1:0] y;
    logic signed [DIR_WIDTH-1:0] z;
  } RayDirection;
  typedef struct packed {
    logic signed [DIR_WIDTH-1:0] x;
    logic signed [DIR_WIDTH-1:0] y;
    logic signed [DIR_WIDTH-1:0] z;
    logic signed [DIR_WIDTH-1:0] len;
  } RayDirection_len;
endpackage

// File: rtl/direction_normalize_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, MSB first
module seq_divider #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] rem, rem_n, q_n;
  logic [W:0] trial, diff;
  logic [CW-1:0] cnt;
  // start performs the first iteration straight from the inputs
  always_comb begin
    trial = {start ? {W{1'b0}} : rem, start ? dividend[W-1] : quotient[W-1]};
    diff = trial - {1'b0, divisor};
    rem_n = diff[W] ? trial[W-1:0] : diff[W-1:0];
    q_n = {start ? dividend[W-2:0] : quotient[W-2:0], ~diff[W]};
  end
  assign busy = cnt != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quotient <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem <= rem_n;
      quotient <= q_n;
      cnt <= CW'(W - 1);
      done <= 1'b0;
    end else if (busy) begin
      rem <= rem_n;
      quotient <= q_n;
      cnt <= cnt - 1'b1;
      done <= cnt == CW'(1);
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/direction_normalize.sv
// direction_normalize: divides each direction component by its length, fixed latency
module direction_normalize
  import direction_normalize_pkg::*;
#(
  parameter int WIDTH = DIR_WIDTH,
  parameter int Q_BITS = DIR_Q_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  RayDirection_len RDLEN_in,
  output logic            ready_out,
  output RayDirection     RD_out,
  output logic            valid_out,
  output logic            div_zero_out,
  output logic            overflow_out
);
  localparam int NORM_ITER = WIDTH + Q_BITS;
  localparam logic [2:0] IDLE = 3'd0, DIV_X = 3'd1, DIV_Y = 3'd2, DIV_Z = 3'd3, DONE = 3'd4;
  localparam logic [NORM_ITER-1:0] MAX_Q = {{(Q_BITS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  logic [2:0] state;
  logic signed [WIDTH-1:0] cx, cy, cz, clen, res_x, res_y, comp;
  logic start, busy, done;
  logic [NORM_ITER-1:0] dividend, divisor, quotient;
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
  function automatic logic signed [WIDTH-1:0] to_signed(input logic [NORM_ITER-1:0] q, input logic neg);
    logic [WIDTH-1:0] mag;
    mag = q > MAX_Q ? MAX_Q[WIDTH-1:0] : q[WIDTH-1:0];
    return neg ? -$signed(mag) : $signed(mag);
  endfunction
  // the next component is launched in the same cycle the previous quotient is taken
  always_comb begin
    comp = state == DIV_X ? (done ? cy : cx) : cz;
    start = (state == DIV_X && !busy) || (state == DIV_Y && done);
    dividend = {mag_of(comp), {Q_BITS{1'b0}}};
    divisor = {{Q_BITS{1'b0}}, clen};
  end
  assign ready_out = state == IDLE;
  seq_divider #(.W(NORM_ITER)) u_div (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      cz <= '0;
      clen <= '0;
      res_x <= '0;
      res_y <= '0;
      RD_out <= '0;
      valid_out <= 1'b0;
      div_zero_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      overflow_out <= valid_in && state != IDLE;
      valid_out <= state == DIV_Z && done;
      div_zero_out <= state == DIV_Z && done && (clen <= 0);
      if (state == IDLE && valid_in) begin
        cx <= RDLEN_in.x;
        cy <= RDLEN_in.y;
        cz <= RDLEN_in.z;
        clen <= RDLEN_in.len;
      end
      if (state == DIV_X && done) res_x <= to_signed(quotient, cx[WIDTH-1]);
      if (state == DIV_Y && done) res_y <= to_signed(quotient, cy[WIDTH-1]);
      if (state == DIV_Z && done) RD_out <= clen > 0 ? {res_x, res_y, to_signed(quotient, cz[WIDTH-1])} : '0;
      state <= state == IDLE ? (valid_in ? DIV_X : IDLE) : state == DONE ? IDLE : done ? state + 3'd1 : state;
    end
  end
endmodule

// File: tb/tb_direction_normalize.sv
// tb_direction_normalize: directed checks of latency, rounding, saturation, overflow, reset
module tb_direction_normalize;
  import direction_normalize_pkg::*;
  logic clk = 1'b0;
  logic reset, valid_in, ready, valid, dz, ovf;
  RayDirection_len rdlen;
  RayDirection rd;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  direction_normalize #(.WIDTH(16), .Q_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .RDLEN_in(rdlen),
    .ready_out(ready),
    .RD_out(rd),
    .valid_out(valid),
    .div_zero_out(dz),
    .overflow_out(ovf)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic RayDirection_len vec(input int x, input int y, input int z, input int l);
    vec.x = 16'(x);
    vec.y = 16'(y);
    vec.z = 16'(z);
    vec.len = 16'(l);
  endfunction
  function automatic logic [63:0] exp3(input int x, input int y, input int z);
    return {16'h0, 16'(x), 16'(y), 16'(z)};
  endfunction
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step;
      n++;
    end while (!valid && n < 100);
  endtask
  task automatic run(input string tag, input RayDirection_len v, input logic [63:0] e, input logic edz);
    int n;
    valid_in = 1'b1;
    rdlen = v;
    step;
    valid_in = 1'b0;
    chk({tag, "_busy"}, ready, 0);
    wait_valid(n);
    chk({tag, "_latency"}, n, 73);
    chk({tag, "_rd"}, rd, e);
    chk({tag, "_dz"}, dz, edz);
    step;
    chk({tag, "_valid_low"}, valid, 0);
    chk({tag, "_dz_low"}, dz, 0);
    chk({tag, "_rd_hold"}, rd, e);
    chk({tag, "_ready"}, ready, 1);
  endtask
  initial begin
    int n, hits;
    reset = 1'b1;
    valid_in = 1'b1;
    rdlen = vec(768, 1024, 0, 1280);
    step;
    step;
    reset = 1'b0;
    valid_in = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_rd", rd, 0);
    chk("rst_dz", dz, 0);
    chk("rst_ovf", ovf, 0);
    step;
    chk("rst_ignored_valid", ready, 1);
    run("v345", vec(768, 1024, 0, 1280), exp3(153, 204, 0), 1'b0);
    run("vneg", vec(-768, 0, 1024, 1280), exp3(-153, 0, 204), 1'b0);
    run("vsat", vec(25600, -25600, 0, 128), exp3(32767, -32767, 0), 1'b0);
    run("vlen0", vec(256, 256, 256, 0), exp3(0, 0, 0), 1'b1);
    run("vmin", vec(-32768, 128, -1, 256), exp3(-32767, 128, -1), 1'b0);
    run("vlenneg", vec(256, -256, 512, -1280), exp3(0, 0, 0), 1'b1);
    run("vmax", vec(32767, -32767, 100, 32767), exp3(256, -256, 0), 1'b0);
    valid_in = 1'b1;
    rdlen = vec(768, 1024, 0, 1280);
    step;
    valid_in = 1'b0;
    repeat (9) step;
    valid_in = 1'b1;
    rdlen = vec(256, 256, 256, 256);
    step;
    valid_in = 1'b0;
    chk("ovf_pulse", ovf, 1);
    chk("ovf_busy", ready, 0);
    step;
    chk("ovf_clear", ovf, 0);
    wait_valid(n);
    chk("ovf_latency", n + 11, 73);
    chk("ovf_rd", rd, exp3(153, 204, 0));
    step;
    valid_in = 1'b1;
    rdlen = vec(-768, 0, 1024, 1280);
    step;
    valid_in = 1'b0;
    wait_valid(n);
    chk("b2b_spacing", n + 2, 75);
    chk("b2b_rd", rd, exp3(-153, 0, 204));
    step;
    valid_in = 1'b1;
    rdlen = vec(25600, -25600, 0, 128);
    step;
    valid_in = 1'b0;
    repeat (29) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_dz", dz, 0);
    chk("mid_rst_ovf", ovf, 0);
    hits = 0;
    repeat (100) begin
      step;
      hits += int'(valid);
    end
    chk("mid_rst_no_valid", hits, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
